// File: rtl/fifo_wptr_ctrl.sv
// fifo_wptr_ctrl
// Write-side pointer controller for the asynchronous FIFO.
//
// This block owns the binary write pointer and its Gray-coded copy. It also
// drives the RAM write strobe and address. It brings the read-domain Gray
// pointer into the write clock through a plain flop chain, then derives the
// full, almost_full and overflow flags from the write pointer and that
// synchronised read pointer.
//
// Pointers are ADDR_WIDTH+1 bits wide. The extra MSB tells a full FIFO
// (pointers differ by exactly one lap) apart from an empty one (pointers
// equal).
//
// The flags are pessimistic. A read only becomes visible here after the
// synchroniser delay, so full and almost_full can stay set for a few cycles
// after space has been freed. They are never cleared too early.
//
// Optional feature, controlled by macro FIFO_WPTR_LEVEL_EN:
//   defined   -> adds registered output wr_level, the occupancy computed on
//                the previous edge.
//   undefined -> no wr_level port. The occupancy subtraction is still built,
//                because almost_full needs it.

module fifo_wptr_ctrl #(
    parameter int ADDR_WIDTH   = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rd_gray_async,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [ADDR_WIDTH:0]   wr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow
`ifdef FIFO_WPTR_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   wr_level
`endif
);

    // Pointer width: one extra bit beyond the RAM address for lap detection.
    localparam int PW = ADDR_WIDTH + 1;

    // Inverting the top two Gray bits of the read pointer yields the Gray
    // code of (read pointer + depth). That is the write pointer value that
    // means "full".
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    // Threshold resized to pointer width. Legal thresholds go up to the
    // depth, which always fits in PW bits.
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    // Write pointer state, binary and Gray.
    logic [PW-1:0] wbin_q;
    logic [PW-1:0] wbin_d;
    logic [PW-1:0] wgray_q;
    logic [PW-1:0] wgray_d;

    // Read-pointer synchroniser chain. Element 0 is the first stage, which
    // faces the asynchronous input.
    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
    logic [PW-1:0]                  rq;
    logic [PW-1:0]                  rbin_sync;

    // Flag state.
    logic          full_q;
    logic          full_d;
    logic          afull_q;
    logic          afull_d;
    logic          ovf_q;
    logic          ovf_d;

    // Occupancy after the current edge.
    logic          accept;
    logic [PW-1:0] level_d;

    // Gray to binary, MSB first: each binary bit is the running XOR of all
    // Gray bits at or above it.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign rq        = sync_q[SYNC_STAGES-1];
    assign rbin_sync = gray2bin(rq);

    // Accept decision, next pointer values and next flag values. All of
    // these are purely combinational, from the current state and the
    // synchronised read pointer.
    always_comb begin
        accept  = wr_en && !full_q && !rst;
        wbin_d  = wbin_q + {{ADDR_WIDTH{1'b0}}, accept};
        wgray_d = wbin_d ^ (wbin_d >> 1);
        full_d  = (wgray_d == (rq ^ FULL_MASK));
        level_d = wbin_d - rbin_sync;
        afull_d = (level_d >= AFULL_LVL);
        ovf_d   = wr_en && full_q;
    end

    // RAM interface. The write lands in the same cycle it is accepted. The
    // strobe is held low while reset is asserted, so a write that is in
    // flight when reset arrives never reaches the RAM.
    assign ram_we    = accept;
    assign ram_waddr = wbin_q[ADDR_WIDTH-1:0];

    // Shift the read-domain Gray pointer through the synchroniser. The
    // stages have no logic between them: a Gray pointer changes one bit per
    // step, so each sampled value is either the old or the new pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rd_gray_async};
        end
    end

    // Register the write pointer in both encodings. Only the Gray copy
    // leaves this clock domain, and it comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin_q  <= '0;
            wgray_q <= '0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
        end
    end

    // Register the status flags. full and almost_full are computed from the
    // next write pointer, so they rise on the same edge as the write that
    // causes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef FIFO_WPTR_LEVEL_EN
    logic [PW-1:0] level_q;

    // Expose the occupancy computed on the previous edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign wr_level = level_q;
`endif

    assign wr_gray     = wgray_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// tb_fifo_wptr_ctrl
// Self-checking bench for fifo_wptr_ctrl with default parameters
// (depth 8, two synchroniser stages, almost-full threshold 6).
//
// The reference model counts writes and reads as unbounded integers. The
// read count reaches the model only after the synchroniser delay. Occupancy
// is the difference between the two counts.

module tb_fifo_wptr_ctrl;

    localparam int AW     = 3;
    localparam int PW     = AW + 1;
    localparam int DEPTH  = 8;
    localparam int SYNC   = 2;
    localparam int THRESH = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [PW-1:0] rd_gray_async;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [PW-1:0] wr_gray;
    logic          full;
    logic          almost_full;
    logic          overflow;
`ifdef FIFO_WPTR_LEVEL_EN
    logic [PW-1:0] wr_level;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int   m_wr;
    int   m_level;
    int   rd_total;
    int   cur_rd;
    logic cur_we;
    logic m_full;
    logic m_afull;
    logic m_ovf;
    int   hist[$];

    logic [PW-1:0] fill_gray [8];

    fifo_wptr_ctrl #(
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (SYNC),
        .AFULL_THRESH(THRESH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_gray_async(rd_gray_async),
        .ram_we       (ram_we),
        .ram_waddr    (ram_waddr),
        .wr_gray      (wr_gray),
        .full         (full),
        .almost_full  (almost_full),
        .overflow     (overflow)
`ifdef FIFO_WPTR_LEVEL_EN
        ,
        .wr_level     (wr_level)
`endif
    );

    always #5 clk = ~clk;

    // Watchdog so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the test sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [PW-1:0] gray_of(input int n);
        int b;
        b = n % (2 * DEPTH);
        return PW'(b ^ (b >> 1));
    endfunction

    task automatic model_reset();
        m_wr     = 0;
        m_level  = 0;
        rd_total = 0;
        cur_rd   = 0;
        cur_we   = 1'b0;
        m_full   = 1'b0;
        m_afull  = 1'b0;
        m_ovf    = 1'b0;
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back(0);
    endtask

    // Drive the producer request and the current read pointer (call at negedge)
    task automatic drive(input logic we);
        wr_en         = we;
        rd_gray_async = gray_of(rd_total);
        cur_we        = we;
        cur_rd        = rd_total;
    endtask

    // Advance one clock edge and update the model, ending at the next negedge
    task automatic tick();
        int   rs;
        logic acc;
        @(posedge clk);
        acc     = cur_we && !m_full;
        m_ovf   = cur_we && m_full;
        m_wr    = m_wr + (acc ? 1 : 0);
        rs      = hist.pop_front();
        hist.push_back(cur_rd);
        m_level = m_wr - rs;
        m_full  = (m_level == DEPTH);
        m_afull = (m_level >= THRESH);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        wr_en         = 1'b0;
        rd_gray_async = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks += 6;
        if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_we got %b want 0", ram_we); end
        if (ram_waddr !== '0) begin errors++; $display("[TB] FAIL reset_waddr got %0h want 0", ram_waddr); end
        if (wr_gray !== '0) begin errors++; $display("[TB] FAIL reset_wr_gray got %0h want 0", wr_gray); end
        if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b want 0", full); end
        if (almost_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_afull got %b want 0", almost_full); end
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b want 0", overflow); end
        drive(1'b0);
        tick();
        checks += 2;
        if (wr_gray !== '0) begin errors++; $display("[TB] FAIL idle_wr_gray got %0h want 0", wr_gray); end
        if (full !== 1'b0) begin errors++; $display("[TB] FAIL idle_full got %b want 0", full); end
    endtask

    task automatic test_fill();
        fill_gray = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'b1100};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1);
            #1;
            checks += 2;
            if (ram_we !== 1'b1) begin errors++; $display("[TB] FAIL fill_we[%0d] got %b want 1", i, ram_we); end
            if (ram_waddr !== AW'(i)) begin errors++; $display("[TB] FAIL fill_waddr[%0d] got %0d want %0d", i, ram_waddr, i); end
            tick();
            checks += 4;
            if (wr_gray !== fill_gray[i]) begin errors++; $display("[TB] FAIL fill_gray[%0d] got %0h want %0h", i, wr_gray, fill_gray[i]); end
            if (almost_full !== (i + 1 >= 6)) begin errors++; $display("[TB] FAIL fill_afull[%0d] got %b want %b", i, almost_full, (i + 1 >= 6)); end
            if (full !== (i == 7)) begin errors++; $display("[TB] FAIL fill_full[%0d] got %b want %b", i, full, (i == 7)); end
            if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fill_ovf[%0d] got %b want 0", i, overflow); end
        end
    endtask

    task automatic test_overflow();
        drive(1'b1);
        #1;
        checks += 2;
        if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL ovf_ram_we got %b want 0", ram_we); end
        if (ram_waddr !== '0) begin errors++; $display("[TB] FAIL ovf_waddr got %0d want 0", ram_waddr); end
        tick();
        checks += 3;
        if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_pulse got %b want 1", overflow); end
        if (wr_gray !== 4'b1100) begin errors++; $display("[TB] FAIL ovf_ptr_hold got %0h want c", wr_gray); end
        if (full !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full got %b want 1", full); end
        drive(1'b0);
        tick();
        checks += 2;
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear got %b want 0", overflow); end
        if (wr_gray !== 4'b1100) begin errors++; $display("[TB] FAIL ovf_ptr_after got %0h want c", wr_gray); end
    endtask

    task automatic test_release();
        rd_total = 3;
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0);
            tick();
            checks += 2;
            if (full !== (k < 3)) begin errors++; $display("[TB] FAIL release_full[edge %0d] got %b want %b", k, full, (k < 3)); end
            if (almost_full !== (k < 3)) begin errors++; $display("[TB] FAIL release_afull[edge %0d] got %b want %b", k, almost_full, (k < 3)); end
        end
    endtask

    // Producer respects full; the consumer trails the writes at a random rate
    task automatic test_wrap();
        int   cyc;
        logic we;
        logic exp_we;
        apply_reset();
        cyc = 0;
        while (m_wr < 40 && cyc < 600) begin
            if (rd_total < m_wr && $urandom_range(0, 3) < (m_wr < 20 ? 2 : 3)) rd_total++;
            we = !full && ($urandom_range(0, 3) != 0);
            drive(we);
            exp_we = we && !m_full;
            #1;
            checks += 2;
            if (ram_we !== exp_we) begin errors++; $display("[TB] FAIL wrap_we[c%0d] got %b want %b", cyc, ram_we, exp_we); end
            if (ram_waddr !== AW'(m_wr % DEPTH)) begin errors++; $display("[TB] FAIL wrap_waddr[c%0d] got %0d want %0d", cyc, ram_waddr, m_wr % DEPTH); end
            tick();
            checks += 4;
            if (wr_gray !== gray_of(m_wr)) begin errors++; $display("[TB] FAIL wrap_gray[c%0d] got %0h want %0h", cyc, wr_gray, gray_of(m_wr)); end
            if (full !== m_full) begin errors++; $display("[TB] FAIL wrap_full[c%0d] got %b want %b", cyc, full, m_full); end
            if (almost_full !== m_afull) begin errors++; $display("[TB] FAIL wrap_afull[c%0d] got %b want %b", cyc, almost_full, m_afull); end
            if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL wrap_ovf[c%0d] got %b want 0", cyc, overflow); end
`ifdef FIFO_WPTR_LEVEL_EN
            checks++;
            if (wr_level !== PW'(m_level)) begin errors++; $display("[TB] FAIL wrap_level[c%0d] got %0d want %0d", cyc, wr_level, m_level); end
`endif
            cyc++;
        end
        checks++;
        if (m_wr < 40) begin errors++; $display("[TB] FAIL wrap_budget writes %0d want 40 within 600 cycles", m_wr); end
    endtask

    // Producer ignores full, so overflow pulses are exercised at random
    task automatic test_random_overflow();
        logic we;
        logic exp_we;
        apply_reset();
        for (int c = 0; c < 200; c++) begin
            if (rd_total < m_wr && $urandom_range(0, 2) == 0) rd_total++;
            we = logic'($urandom_range(0, 1));
            drive(we);
            exp_we = we && !m_full;
            #1;
            checks++;
            if (ram_we !== exp_we) begin errors++; $display("[TB] FAIL rovf_we[c%0d] got %b want %b", c, ram_we, exp_we); end
            tick();
            checks += 4;
            if (wr_gray !== gray_of(m_wr)) begin errors++; $display("[TB] FAIL rovf_gray[c%0d] got %0h want %0h", c, wr_gray, gray_of(m_wr)); end
            if (full !== m_full) begin errors++; $display("[TB] FAIL rovf_full[c%0d] got %b want %b", c, full, m_full); end
            if (almost_full !== m_afull) begin errors++; $display("[TB] FAIL rovf_afull[c%0d] got %b want %b", c, almost_full, m_afull); end
            if (overflow !== m_ovf) begin errors++; $display("[TB] FAIL rovf_ovf[c%0d] got %b want %b", c, overflow, m_ovf); end
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1);
            tick();
        end
        drive(1'b1);
        #1;
        checks += 2;
        if (ram_we !== 1'b1) begin errors++; $display("[TB] FAIL midrst_we_before got %b want 1", ram_we); end
        if (ram_waddr !== AW'(4)) begin errors++; $display("[TB] FAIL midrst_waddr_before got %0d want 4", ram_waddr); end
        rst = 1'b1;
        #1;
        checks += 6;
        if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ram_we got %b want 0", ram_we); end
        if (ram_waddr !== '0) begin errors++; $display("[TB] FAIL midrst_waddr got %0d want 0", ram_waddr); end
        if (wr_gray !== '0) begin errors++; $display("[TB] FAIL midrst_wr_gray got %0h want 0", wr_gray); end
        if (full !== 1'b0) begin errors++; $display("[TB] FAIL midrst_full got %b want 0", full); end
        if (almost_full !== 1'b0) begin errors++; $display("[TB] FAIL midrst_afull got %b want 0", almost_full); end
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ovf got %b want 0", overflow); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(1'b1);
        #1;
        checks += 2;
        if (ram_we !== 1'b1) begin errors++; $display("[TB] FAIL midrst_we_after got %b want 1", ram_we); end
        if (ram_waddr !== '0) begin errors++; $display("[TB] FAIL midrst_waddr_after got %0d want 0", ram_waddr); end
        tick();
        checks++;
        if (wr_gray !== 4'd1) begin errors++; $display("[TB] FAIL midrst_gray_after got %0h want 1", wr_gray); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_wrap();
        test_random_overflow();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wptr_ctrl.md
Name: fifo_wptr_ctrl

Overview:
- Write-side pointer controller for the team's asynchronous FIFO.
- Owns the binary write pointer and its Gray-coded copy, and issues the RAM write address and write enable.
- Synchronises the read-domain Gray pointer into the write clock and generates full, almost_full and overflow.
- Sits between the write-side producer and the dual-port RAM. The Gray pointer it exports feeds the read-side controller's synchroniser.

Parameters:
- ADDR_WIDTH, 3, RAM address width. FIFO depth = 2**ADDR_WIDTH. Pointers are ADDR_WIDTH+1 bits wide.
- SYNC_STAGES, 2, flip-flop stages in the read-pointer synchroniser. Legal values are 2 or more.
- AFULL_THRESH, 6, almost_full asserts when occupancy >= AFULL_THRESH. Legal range is 1 to 2**ADDR_WIDTH.

Ports:
- clk  input  1  write-domain clock
- rst  input  1  asynchronous, active-high reset
- wr_en  input  1  producer write request
- rd_gray_async  input  ADDR_WIDTH+1  read pointer, Gray-coded, from the read clock domain
- ram_we  output  1  RAM write strobe; equals wr_en && !full (combinational)
- ram_waddr  output  ADDR_WIDTH  RAM write address; low bits of the binary write pointer
- wr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, exported to the read domain
- full  output  1  registered full flag
- almost_full  output  1  registered almost-full flag
- overflow  output  1  one-cycle pulse when wr_en is asserted while full

Behaviour:
- Reset (asynchronous, active-high): all of the following clear to 0 immediately.
  - wbin, wr_gray, all synchroniser stages
  - full, almost_full, overflow
  - ram_waddr = 0; ram_we = 0 (because wr_en is gated until release)
- Accept rule: write accepted in a cycle where wr_en=1 and full=0.
- Next-state values:
  - wbin_next = wbin + accepted, with natural wrap modulo 2**(ADDR_WIDTH+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - Both register on the next rising clk edge.
- Timing of the write:
  - ram_waddr = wbin[ADDR_WIDTH-1:0] is the address in the cycle the write is accepted.
  - ram_we is asserted in that same cycle. Write latency is 0 cycles.
- Synchroniser:
  - rd_gray_async passes through SYNC_STAGES flops; the last stage is rq.
  - No logic between stages.
- Read pointer in binary:
  - rbin_sync = Gray-to-binary of rq, computed MSB-first by XOR prefix: rbin[i] = rbin[i+1] ^ rq[i].
- Full:
  - full_next = (wgray_next == {~rq[MSB:MSB-1], rq[MSB-2:0]}).
  - Registered, so full rises on the same edge as the write that fills the FIFO.
- Occupancy and almost_full:
  - level_next = wbin_next - rbin_sync, modulo 2**(ADDR_WIDTH+1). Range is 0 to 2**ADDR_WIDTH.
  - almost_full_next = (level_next >= AFULL_THRESH). Registered.
- Overflow:
  - overflow = 1 for exactly the cycle after any clock where wr_en=1 and full=1.
  - Pointer is unchanged and ram_we=0 during such a rejected write.
- Release latency: a read-side pointer advance clears full and almost_full no earlier than SYNC_STAGES+1 clk edges after rd_gray_async changes. These flags are pessimistic by design.
- Wrap-around: the binary pointer MSB toggles every 2**ADDR_WIDTH writes. The full comparison uses the inverted top two Gray bits; other cases needing no special handling.
- Simultaneous events:
  - Write accepted on the same edge that the synchronised read pointer advances: the flags use both new values; there is no priority.
  - Writes while full are dropped and flagged with overflow; there is no stall state.
- Reset asserted mid-write: the write is lost; the pointer returns to 0. System reset must reset both FIFO sides together.
- wr_gray is driven directly from a register, with no combinational output path.

Optional Feature:
- Macro: FIFO_WPTR_LEVEL_EN.
- Defined:
  - Adds output port wr_level [ADDR_WIDTH:0], registered, equal to level_next from the previous edge.
  - wr_level resets to 0.
- Undefined:
  - Port is absent.
  - The level subtraction is still built for almost_full; nothing else changes.

Test Plan:
- Reset then idle, rd_gray_async=0 -> ram_waddr=0, wr_gray=0, full=0, almost_full=0, overflow=0.
- 8 consecutive writes, rd_gray_async=0 ->
  - ram_waddr runs 0..7; wr_gray runs 1,3,2,6,7,5,4 and then 0b01100 after the 8th write.
  - almost_full rises after the 6th write; full rises after the 8th.
- 9th write while full -> ram_we=0, pointer unchanged, overflow=1 for one cycle.
- From full, drive rd_gray_async=Gray(3)=0b00010 -> full clears exactly 3 edges later with SYNC_STAGES=2. almost_full clears (level 5 < 6).
- Run 40 writes with rd_gray_async tracking wr_gray after a delay -> pointer wraps through 16 correctly, no false full, no overflow. Compare against a reference FIFO model.
- Assert rst mid-burst at write 5 -> all outputs are 0 asynchronously, before the next edge. After release the next write goes to ram_waddr=0.
